bcd_conv_sched: RTL

//   Shared, multi-cycle binary-to-BCD conversion engine serving two requesters.

---
 rtl/bcd_conv_sched_if.sv | 34 +++
 rtl/bcd_conv_sched.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched_if.sv
// Request/result bus for the shared binary-to-BCD converter.
// master = requesters and result consumer, slave = converter.
interface bcd_conv_sched_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [WIDTH-1:0]      req0_num;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [WIDTH-1:0]      req1_num;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;
  logic                  out_src;

  modport master (
    output req0_valid, req0_num,
    output req1_valid, req1_num,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_bcd, out_ovf, out_src
  );

  modport slave (
    input  req0_valid, req0_num,
    input  req1_valid, req1_num,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_bcd, out_ovf, out_src
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared double-dabble BCD converter, round-robin between two
// requesters, one bit per clock, result tagged with its source.
module bcd_conv_sched #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_conv_sched_if.slave      bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MAXV = 10 ** DIGITS - 1;
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   sh_q, sh_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic [BW-1:0]   out_bcd_q, out_bcd_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_src_q, out_src_d;

  logic            grant0, grant1;
  logic            rdy0, rdy1;
  logic [WIDTH-1:0] num_sel;
  logic [BW-1:0]   adj;

  // ptr_q high means req1 wins a tie
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ptr_q);
  assign rdy0   = (state_q == IDLE) & grant0;
  assign rdy1   = (state_q == IDLE) & grant1;

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bcd    = out_bcd_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_src    = out_src_q;

  always_comb begin
    adj = sh_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[4*d +: 4] > 4'd4)
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    sh_d        = sh_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_ovf_d   = out_ovf_q;
    out_src_d   = out_src_q;
    num_sel     = rdy1 ? bus.req1_num : bus.req0_num;
    unique case (state_q)
      IDLE: begin
        if (rdy0 | rdy1) begin
          bin_d     = num_sel;
          sh_d      = '0;
          cnt_d     = '0;
          ovf_d     = 32'(num_sel) > MAXV;
          out_src_d = rdy1;
          ptr_d     = ~rdy1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {sh_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_ovf_d   = ovf_q;
          out_bcd_d   = ovf_q ? NINES
                              : {adj[BW-2:0], bin_q[WIDTH-1]};
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      bin_q       <= '0;
      sh_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      sh_q        <= sh_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_ovf_q   <= out_ovf_d;
      out_src_q   <= out_src_d;
    end
  end

endmodule
